// File: rtl/data_memory_access_controller.sv
// rtl/data_memory_access_controller.sv - MEM-stage load/store sequencer for a req/ready data bus
module data_memory_access_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic        BUSY,
  output logic [31:0] LOAD_DATA,
  output logic        MISALIGNED,
  output logic        BUS_TIMEOUT,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_BE,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_READY,
  input  logic [31:0] BUS_RDATA
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [7:0]  count;
  logic [8:0]  count_inc;
  logic [1:0]  addr_lo;
  logic [2:0]  func3_q;
  logic        timeout_flag;
  logic        request, half, word, misaligned_req, timed_out;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_value;

  // Loads map illegal widths onto LW; stores map everything above SH onto SW.
  always_comb begin
    request = MEM_READ | MEM_WRITE;
    if (MEM_READ) begin
      half = (FUNC3[1:0] == 2'b01);
      word = FUNC3[1];
    end else begin
      half = (FUNC3 == 3'b001);
      word = (FUNC3 != 3'b000) && (FUNC3 != 3'b001);
    end
    misaligned_req = (half & ADDRESS[0]) | (word & (ADDRESS[1:0] != 2'b00));
    be_next    = 4'b1111;
    wdata_next = WRITE_DATA;
    if (!MEM_READ) begin
      if (half) begin
        be_next    = 4'b0011 << {ADDRESS[1], 1'b0};
        wdata_next = {2{WRITE_DATA[15:0]}};
      end else if (!word) begin
        be_next    = 4'b0001 << ADDRESS[1:0];
        wdata_next = {4{WRITE_DATA[7:0]}};
      end
    end
  end

  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = BUS_RDATA[7:0];
      2'd1:    lane_byte = BUS_RDATA[15:8];
      2'd2:    lane_byte = BUS_RDATA[23:16];
      default: lane_byte = BUS_RDATA[31:24];
    endcase
    lane_half = addr_lo[1] ? BUS_RDATA[31:16] : BUS_RDATA[15:0];
    case (func3_q)
      3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_value = {24'd0, lane_byte};
      3'b101:  load_value = {16'd0, lane_half};
      default: load_value = BUS_RDATA;
    endcase
  end

  always_comb begin
    state_next = state;
    count_inc  = {1'b0, count} + 9'd1;
    timed_out  = (count_inc == TIMEOUT_LIMIT);
    case (state)
      IDLE:    if (request) state_next = misaligned_req ? FAULT : ACCESS;
      ACCESS: begin
        if (BUS_READY)      state_next = DONE;
        else if (timed_out) state_next = FAULT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state        <= IDLE;
      count        <= 8'd0;
      addr_lo      <= 2'd0;
      func3_q      <= 3'd0;
      timeout_flag <= 1'b0;
      LOAD_DATA    <= 32'd0;
      BUS_WE       <= 1'b0;
      BUS_ADDR     <= 32'd0;
      BUS_BE       <= 4'd0;
      BUS_WDATA    <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (request) begin
            timeout_flag <= 1'b0;
            count        <= 8'd0;
            if (misaligned_req) begin
              LOAD_DATA <= 32'd0;
            end else begin
              addr_lo   <= ADDRESS[1:0];
              func3_q   <= FUNC3;
              BUS_WE    <= ~MEM_READ;
              BUS_ADDR  <= {ADDRESS[31:2], 2'b00};
              BUS_BE    <= be_next;
              BUS_WDATA <= wdata_next;
            end
          end
        end
        ACCESS: begin
          count <= count_inc[7:0];
          if (BUS_READY) begin
            if (!BUS_WE) LOAD_DATA <= load_value;
          end else if (timed_out) begin
            timeout_flag <= 1'b1;
            LOAD_DATA    <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY        = RESET & (((state == IDLE) & request) | (state == ACCESS));
  assign BUS_REQ     = (state == ACCESS);
  assign MISALIGNED  = (state == FAULT) & ~timeout_flag;
  assign BUS_TIMEOUT = (state == FAULT) & timeout_flag;

endmodule

// File: tb/tb_data_memory_access_controller.sv
// tb/tb_data_memory_access_controller.sv - directed scoreboard bench for data_memory_access_controller
module tb_data_memory_access_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MEM_READ = 1'b0, MEM_WRITE = 1'b0;
  logic [2:0]  FUNC3 = 3'd0;
  logic [31:0] ADDRESS = 32'd0, WRITE_DATA = 32'd0;
  logic        BUSY, MISALIGNED, BUS_TIMEOUT, BUS_REQ, BUS_WE;
  logic [31:0] LOAD_DATA, BUS_ADDR, BUS_WDATA;
  logic [3:0]  BUS_BE;
  logic        BUS_READY = 1'b0;
  logic [31:0] BUS_RDATA = 32'd0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'd0;

  always #5 CLK = ~CLK;

  data_memory_access_controller #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .FUNC3(FUNC3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .BUSY(BUSY),
    .LOAD_DATA(LOAD_DATA), .MISALIGNED(MISALIGNED), .BUS_TIMEOUT(BUS_TIMEOUT),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_BE(BUS_BE),
    .BUS_WDATA(BUS_WDATA), .BUS_READY(BUS_READY), .BUS_RDATA(BUS_RDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drop_request();
    MEM_READ = 1'b0;
    MEM_WRITE = 1'b0;
  endtask

  // One complete aligned access; the bus answers after `waits` ACCESS cycles.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                        input int waits, input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_ld);
    int cyc = 0;
    int busy_cycles = 0;
    next_cycle();
    MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; ADDRESS = addr; WRITE_DATA = wd;
    exp_q.push_back(exp_ld);
    #1;
    chk({tag, " req_c0"}, 32'(BUS_REQ), 32'd0);
    while (BUSY === 1'b1 && cyc < 50) begin
      busy_cycles++;
      if (cyc >= 1) chk({tag, " req_held"}, 32'(BUS_REQ), 32'd1);
      if (cyc == 1) begin
        chk({tag, " addr"}, BUS_ADDR, {addr[31:2], 2'b00});
        chk({tag, " we"}, 32'(BUS_WE), 32'(exp_we));
        chk({tag, " be"}, 32'(BUS_BE), 32'(exp_be));
        if (exp_we) chk({tag, " wdata"}, BUS_WDATA, exp_wd);
      end
      next_cycle();
      cyc++;
      BUS_READY = (cyc == waits + 1);
      BUS_RDATA = rdat;
      #1;
    end
    BUS_READY = 1'b0;
    chk({tag, " busy_cycles"}, 32'(busy_cycles), 32'(waits + 2));
    chk({tag, " req_done"}, 32'(BUS_REQ), 32'd0);
    chk({tag, " load"}, LOAD_DATA, exp_q.pop_front());
    drop_request();
  endtask

  initial begin
    MEM_READ = 1'b1;
    next_cycle();
    chk("reset busy", 32'(BUSY), 32'd0);
    next_cycle();
    chk("reset req", 32'(BUS_REQ), 32'd0);
    chk("reset load", LOAD_DATA, 32'd0);
    chk("reset be", 32'(BUS_BE), 32'd0);
    chk("reset addr", BUS_ADDR, 32'd0);
    chk("reset faults", 32'({MISALIGNED, BUS_TIMEOUT}), 32'd0);
    MEM_READ = 1'b0;
    RESET = 1'b1;

    access("lb103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 2, 0, 4'b1111, 32'h0, 32'hFFFF_FF80);
    access("lh102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 0, 0, 4'b1111, 32'h0, 32'hFFFF_80FF);
    access("lhu102", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 1, 0, 4'b1111, 32'h0, 32'h0000_80FF);
    access("lbu100", 1, 0, 3'b100, 32'h100, 32'h0, 32'h80FF_1234, 0, 0, 4'b1111, 32'h0, 32'h0000_0034);
    access("lb101", 1, 0, 3'b000, 32'h101, 32'h0, 32'h80FF_1234, 1, 0, 4'b1111, 32'h0, 32'h0000_0012);
    access("lw100", 1, 0, 3'b010, 32'h100, 32'h0, 32'h80FF_1234, 0, 0, 4'b1111, 32'h0, 32'h80FF_1234);
    last_load = 32'h80FF_1234;
    access("sb201", 0, 1, 3'b000, 32'h201, 32'h0000_00AB, 32'h1111_1111, 1, 1, 4'b0010, 32'hABAB_ABAB, last_load);
    access("sh202", 0, 1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h2222_2222, 0, 1, 4'b1100, 32'hBEEF_BEEF, last_load);
    access("sw204", 0, 1, 3'b010, 32'h204, 32'h1234_5678, 32'h3333_3333, 0, 1, 4'b1111, 32'h1234_5678, last_load);

    // Misaligned word load: single stall cycle, fault pulse, no bus activity
    next_cycle();
    MEM_READ = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h006;
    #1;
    chk("mis busy_c0", 32'(BUSY), 32'd1);
    next_cycle();
    drop_request();
    #1;
    chk("mis pulse", 32'(MISALIGNED), 32'd1);
    chk("mis no_timeout", 32'(BUS_TIMEOUT), 32'd0);
    chk("mis req", 32'(BUS_REQ), 32'd0);
    chk("mis busy_c1", 32'(BUSY), 32'd0);
    chk("mis load", LOAD_DATA, 32'd0);
    next_cycle();
    chk("mis pulse_end", 32'(MISALIGNED), 32'd0);

    // Timeout after four unanswered ACCESS cycles
    next_cycle();
    MEM_READ = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h300;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      chk($sformatf("to req_c%0d", i), 32'(BUS_REQ), 32'd1);
      chk($sformatf("to busy_c%0d", i), 32'(BUSY), 32'd1);
    end
    next_cycle();
    drop_request();
    #1;
    chk("to pulse", 32'(BUS_TIMEOUT), 32'd1);
    chk("to no_mis", 32'(MISALIGNED), 32'd0);
    chk("to busy_c5", 32'(BUSY), 32'd0);
    chk("to req_c5", 32'(BUS_REQ), 32'd0);
    next_cycle();
    BUS_READY = 1'b1; BUS_RDATA = 32'hDEAD_BEEF;
    #1;
    chk("late ready pulse_end", 32'(BUS_TIMEOUT), 32'd0);
    chk("late ready req", 32'(BUS_REQ), 32'd0);
    next_cycle();
    BUS_READY = 1'b0;
    #1;
    chk("late ready busy", 32'(BUSY), 32'd0);
    chk("late ready load", LOAD_DATA, 32'd0);

    // Reset while the access is outstanding
    next_cycle();
    MEM_READ = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h100;
    next_cycle();
    chk("rst req_pre", 32'(BUS_REQ), 32'd1);
    RESET = 1'b0;
    #1;
    chk("rst busy_forced", 32'(BUSY), 32'd0);
    next_cycle();
    chk("rst req_cleared", 32'(BUS_REQ), 32'd0);
    chk("rst faults", 32'({MISALIGNED, BUS_TIMEOUT}), 32'd0);
    drop_request();
    RESET = 1'b1;
    next_cycle();
    chk("rst idle busy", 32'(BUSY), 32'd0);
    chk("rst idle req", 32'(BUS_REQ), 32'd0);
    chk("rst idle faults", 32'({MISALIGNED, BUS_TIMEOUT}), 32'd0);

    access("both", 1, 1, 3'b010, 32'h400, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1, 0, 4'b1111, 32'h0, 32'hCAFE_F00D);

    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_access_controller.md
Name: data_memory_access_controller

Overview:
- Sequences MEM-stage loads and stores onto a variable-latency data-memory bus with a req/ready handshake.
- Stalls the pipeline while a bus access is outstanding.
- Generates byte enables and lane-replicated store data.
- Performs the FUNC3-driven load lane-select and sign/zero-extension, then hands the result back to the pipeline with a one-cycle completion window.

Parameters:
- TIMEOUT_CYCLES, 255, number of ACCESS-state cycles without BUS_READY before the access is aborted (1..255).

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-low reset
- MEM_READ  input  1  MEM-stage load request, held by the pipeline while BUSY=1
- MEM_WRITE  input  1  MEM-stage store request, held while BUSY=1
- FUNC3  input  3  RV32 load/store width code
- ADDRESS  input  32  byte address of the access
- WRITE_DATA  input  32  store data, right-aligned
- BUSY  output  1  pipeline stall request
- LOAD_DATA  output  32  processed load result, valid in DONE
- MISALIGNED  output  1  one-cycle fault pulse, alignment violation
- BUS_TIMEOUT  output  1  one-cycle fault pulse, bus did not respond
- BUS_REQ  output  1  bus request, held until BUS_READY
- BUS_WE  output  1  1 = write, 0 = read
- BUS_ADDR  output  32  word address, {ADDRESS[31:2], 2'b00}
- BUS_BE  output  4  byte enables
- BUS_WDATA  output  32  lane-replicated store data
- BUS_READY  input  1  bus completion, sampled only while BUS_REQ=1
- BUS_RDATA  input  32  read word, valid when BUS_READY=1

Behaviour:
- Reset (RESET=0 at an edge):
  - state <= IDLE; all registered outputs, timeout counter and the captured address/FUNC3 are cleared.
  - BUSY is forced to 0 while RESET=0.
  - Reset mid-access aborts it: BUS_REQ=0 after that edge, no DONE, no fault pulse.
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE, request = MEM_READ | MEM_WRITE:
  - If both are high, the access is a read.
  - BUSY = request (combinational), so the stall starts in the request cycle.
  - Aligned request: latch address, FUNC3, direction, BUS_BE and BUS_WDATA; assert BUS_REQ; go to ACCESS.
  - Misaligned request: go to FAULT with no bus transaction. Misaligned means halfword with ADDRESS[0]=1, or word with ADDRESS[1:0]!=0.
- ACCESS:
  - BUSY=1; BUS_* outputs stable; counter increments each cycle.
  - BUS_READY=1: capture the processed load (reads only), drop BUS_REQ, go to DONE.
  - Else, if the counter reaches TIMEOUT_CYCLES: drop BUS_REQ, go to FAULT with the timeout flag set.
- DONE:
  - BUSY=0, LOAD_DATA valid (held stable until the next load completes); always returns to IDLE.
  - Request inputs are ignored in this cycle, because the pipeline advances at the closing edge.
- FAULT:
  - BUSY=0; exactly one of MISALIGNED or BUS_TIMEOUT is 1; LOAD_DATA <= 0; returns to IDLE.
- Minimum latency: request at c0, ACCESS c1 with BUS_READY=1, DONE c2. BUSY is high for c0–c1 and low at c2.
- Each wait cycle adds one cycle of latency.
- Loads, selected by ADDRESS[1:0]; illegal codes 011/110/111 behave as LW:
  - LB (000): byte lane sign-extended.
  - LH (001): halfword at ADDRESS[1] sign-extended.
  - LW (010): full word.
  - LBU (100): byte lane zero-extended.
  - LHU (101): halfword zero-extended.
  - BUS_BE = 4'b1111 for all loads.
- Stores; FUNC3 codes other than 000/001/010 behave as SW:
  - SB: BUS_BE = 4'b0001 << ADDRESS[1:0]; BUS_WDATA = {4{WRITE_DATA[7:0]}}.
  - SH: BUS_BE = 4'b0011 << {ADDRESS[1],1'b0}; BUS_WDATA = {2{WRITE_DATA[15:0]}}.
  - SW: BUS_BE = 4'b1111; BUS_WDATA = WRITE_DATA.
  - LOAD_DATA is unchanged by stores.
- BUS_READY high outside ACCESS is ignored.

Test Plan:
1. LB at 0x0000_0103; bus returns 0x80FF_1234 after two wait cycles -> BUS_ADDR=0x100, BUS_BE=1111, BUSY high c0–c3, DONE at c4 with LOAD_DATA=0xFFFF_FF80.
2. LH at 0x102 with RDATA 0x80FF_1234 -> 0xFFFF_80FF. LHU at the same address -> 0x0000_80FF. LBU at 0x100 -> 0x0000_0034. LW at 0x100 -> 0x80FF_1234.
3. SB at 0x201, WRITE_DATA=0x0000_00AB -> BUS_WE=1, BUS_ADDR=0x200, BUS_BE=0010, BUS_WDATA=0xABAB_ABAB, LOAD_DATA unchanged. SH at 0x202, data 0x0000_BEEF -> BE=1100, WDATA=0xBEEF_BEEF.
4. LW at 0x006 -> BUS_REQ never asserted, BUSY high c0 only, MISALIGNED=1 at c1 for exactly one cycle, LOAD_DATA=0.
5. TIMEOUT_CYCLES=4 with BUS_READY held low -> BUS_REQ high for 4 cycles, BUS_TIMEOUT pulse at c5, BUSY low at c5. A late BUS_READY at c6 is ignored.
6. RESET=0 during ACCESS -> IDLE after that edge, BUS_REQ=0, no DONE or fault pulse. MEM_READ and MEM_WRITE both high -> BUS_WE=0 (read performed).
